// File: rtl/alu_issue_ctrl.sv
// Operand/issue stage in front of the 16-bit ALU: one instruction in flight,
// walked through IDLE -> EXEC -> WB with an internal 8-entry register file.
module alu_issue_ctrl #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [15:0]      INSTR,
   input  logic             INSTR_VLD,
   output logic             INSTR_RDY,
   output logic [2:0]       ALU_OP,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] ALU_OUT,
   input  logic             ZF,
   output logic [WIDTH-1:0] WB_DATA,
   output logic             ZF_REG,
   output logic             DONE,
   input  logic [2:0]       DBG_ADDR,
   output logic [WIDTH-1:0] DBG_DATA,
   output logic [1:0]       DBG_STATE
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   // Handshake: a word transfers on a rising edge where INSTR_VLD and
   // INSTR_RDY are both high; INSTR_RDY is high only in IDLE, so a word held
   // during EXEC/WB is ignored until the next IDLE edge.

   logic [1:0]       state;
   logic [15:0]      ir;
   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH-1:0] wb_data;
   logic             zf_reg;

   logic [2:0]       op_f;
   logic [2:0]       rd_f;
   logic [2:0]       rs_f;
   logic [2:0]       rt_f;
   logic             imm_sel_f;
   logic [2:0]       imm3_f;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;

   assign op_f      = ir[15:13];
   assign rd_f      = ir[12:10];
   assign rs_f      = ir[9:7];
   assign rt_f      = ir[6:4];
   assign imm_sel_f = ir[3];
   assign imm3_f    = ir[2:0];

   // R0 reads as zero regardless of storage contents.
   assign rs_val   = (rs_f == 3'd0)     ? '0 : regs[rs_f];
   assign rt_val   = (rt_f == 3'd0)     ? '0 : regs[rt_f];
   assign DBG_DATA = (DBG_ADDR == 3'd0) ? '0 : regs[DBG_ADDR];

   assign INSTR_RDY = (state == S_IDLE);
   assign DONE      = (state == S_WB);
   assign WB_DATA   = wb_data;
   assign ZF_REG    = zf_reg;
   assign DBG_STATE = state;

   always_comb begin
      ALU_OP = 3'd0;
      A      = '0;
      B      = '0;
      if (state == S_EXEC) begin
         ALU_OP = op_f;
         A      = rs_val;
         B      = imm_sel_f ? {{(WIDTH-3){1'b0}}, imm3_f} : rt_val;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         ir      <= '0;
         wb_data <= '0;
         zf_reg  <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (INSTR_VLD) begin
                  ir    <= INSTR;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               wb_data <= ALU_OUT;
               zf_reg  <= ZF;
               state   <= S_WB;
            end
            S_WB: begin
               // Writes to R0 are dropped; WB_DATA/ZF_REG already updated.
               if (rd_f != 3'd0) begin
                  regs[rd_f] <= wb_data;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached to
// the ALU_OP/A/B -> ALU_OUT/ZF loop.
module tb_alu_issue_ctrl;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic [15:0]      instr;
   logic             instr_vld;
   logic             instr_rdy;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] alu_out;
   logic             zf;
   logic [WIDTH-1:0] wb_data;
   logic             zf_reg;
   logic             done;
   logic [2:0]       dbg_addr;
   logic [WIDTH-1:0] dbg_data;
   logic [1:0]       dbg_state;

   int checks   = 0;
   int failures = 0;

   alu_issue_ctrl #(.WIDTH(WIDTH), .NREG(8)) dut (
      .CLK       (clk),
      .RST       (rst),
      .INSTR     (instr),
      .INSTR_VLD (instr_vld),
      .INSTR_RDY (instr_rdy),
      .ALU_OP    (alu_op),
      .A         (a),
      .B         (b),
      .ALU_OUT   (alu_out),
      .ZF        (zf),
      .WB_DATA   (wb_data),
      .ZF_REG    (zf_reg),
      .DONE      (done),
      .DBG_ADDR  (dbg_addr),
      .DBG_DATA  (dbg_data),
      .DBG_STATE (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor,
   // 101 shl, 110 shr, 111 signed slt
   always_comb begin
      alu_out = '0;
      case (alu_op)
         3'd0: alu_out = a + b;
         3'd1: alu_out = a - b;
         3'd2: alu_out = a & b;
         3'd3: alu_out = a | b;
         3'd4: alu_out = a ^ b;
         3'd5: alu_out = a << b[3:0];
         3'd6: alu_out = a >> b[3:0];
         default: alu_out = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      endcase
      zf = (alu_out == '0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
      dbg_addr = idx;
      #1;
      check(tag, {16'd0, dbg_data}, {16'd0, exp});
   endtask

   // Full instruction from IDLE: accept, EXEC checks, WB checks, back to IDLE.
   task automatic run_instr(input string tag, input logic [15:0] word,
                            input logic [2:0] exp_op, input logic [15:0] exp_a,
                            input logic [15:0] exp_b, input logic [15:0] exp_wb,
                            input logic exp_zf);
      check({tag, "_rdy_idle"}, {31'd0, instr_rdy}, 32'd1);
      instr     = word;
      instr_vld = 1'b1;
      step();
      instr_vld = 1'b0;
      instr     = $urandom_range(0, 16'hffff);
      check({tag, "_rdy_exec"}, {31'd0, instr_rdy}, 32'd0);
      check({tag, "_op"},       {29'd0, alu_op}, {29'd0, exp_op});
      check({tag, "_a"},        {16'd0, a}, {16'd0, exp_a});
      check({tag, "_b"},        {16'd0, b}, {16'd0, exp_b});
      check({tag, "_done_exec"},{31'd0, done}, 32'd0);
      step();
      check({tag, "_done_wb"},  {31'd0, done}, 32'd1);
      check({tag, "_wb_data"},  {16'd0, wb_data}, {16'd0, exp_wb});
      check({tag, "_zf_reg"},   {31'd0, zf_reg}, {31'd0, exp_zf});
      check({tag, "_op_wb"},    {29'd0, alu_op}, 32'd0);
      step();
      check({tag, "_done_idle"},{31'd0, done}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      instr     = 16'h0000;
      instr_vld = 1'b0;
      dbg_addr  = 3'd0;
      step();
      step();
      rst = 1'b0;

      // reset state
      check("rst_rdy",   {31'd0, instr_rdy}, 32'd1);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_wb",    {16'd0, wb_data}, 32'd0);
      check("rst_zf",    {31'd0, zf_reg}, 32'd0);
      check("rst_op",    {29'd0, alu_op}, 32'd0);
      check("rst_a",     {16'd0, a}, 32'd0);
      check("rst_b",     {16'd0, b}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      check_reg("rst_r1", 3'd1, 16'd0);

      // R1 = R0 + 5
      run_instr("add_imm", 16'h040D, 3'd0, 16'd0, 16'd5, 16'd5, 1'b0);
      check_reg("add_imm_r1", 3'd1, 16'd5);

      // R2 = R1 - R1 -> 0 with zero flag
      run_instr("sub_zero", 16'h2890, 3'd1, 16'd5, 16'd5, 16'd0, 1'b1);
      check_reg("sub_zero_r2", 3'd2, 16'd0);
      check_reg("sub_zero_r1", 3'd1, 16'd5);

      // R0 = R0 + 7: result visible on WB_DATA, R0 stays zero
      run_instr("r0_wr", 16'h000F, 3'd0, 16'd0, 16'd7, 16'd7, 1'b0);
      check_reg("r0_wr_r0", 3'd0, 16'd0);

      // Backpressure: VLD held high with R1 = R0+3 then R2 = R0+4;
      // the second word is presented while not ready.
      instr     = 16'h040B;
      instr_vld = 1'b1;
      step();
      instr = 16'h080C;
      check("bp_rdy_exec1", {31'd0, instr_rdy}, 32'd0);
      check("bp_b1",        {16'd0, b}, 32'd3);
      step();
      check("bp_rdy_wb1",   {31'd0, instr_rdy}, 32'd0);
      check("bp_done1",     {31'd0, done}, 32'd1);
      check("bp_wb1",       {16'd0, wb_data}, 32'd3);
      step();
      check("bp_rdy_idle",  {31'd0, instr_rdy}, 32'd1);
      check("bp_done_gap",  {31'd0, done}, 32'd0);
      step();
      instr_vld = 1'b0;
      check("bp_rdy_exec2", {31'd0, instr_rdy}, 32'd0);
      check("bp_b2",        {16'd0, b}, 32'd4);
      check("bp_done_gap2", {31'd0, done}, 32'd0);
      step();
      check("bp_done2",     {31'd0, done}, 32'd1);
      check("bp_wb2",       {16'd0, wb_data}, 32'd4);
      step();
      check("bp_done_end",  {31'd0, done}, 32'd0);
      check_reg("bp_r1", 3'd1, 16'd3);
      check_reg("bp_r2", 3'd2, 16'd4);

      // 0xEC94 decodes to rs=1, rt=1: R3 = (R1 < R1) = 0
      run_instr("slt_same", 16'hEC94, 3'd7, 16'd3, 16'd3, 16'd0, 1'b1);
      check_reg("slt_same_r3", 3'd3, 16'd0);
      // 0xECA0 decodes to rs=1, rt=2: R3 = (R1 < R2) = 1
      run_instr("slt", 16'hECA0, 3'd7, 16'd3, 16'd4, 16'd1, 1'b0);
      check_reg("slt_r3", 3'd3, 16'd1);

      // Build R1 = 9 (R0+7, then R1+2), then reset during EXEC
      run_instr("ld7", 16'h040F, 3'd0, 16'd0, 16'd7, 16'd7, 1'b0);
      run_instr("ld9", 16'h048A, 3'd0, 16'd7, 16'd2, 16'd9, 1'b0);
      check_reg("ld9_r1", 3'd1, 16'd9);
      instr     = 16'h040D;
      instr_vld = 1'b1;
      step();
      instr_vld = 1'b0;
      check("mid_exec_rdy", {31'd0, instr_rdy}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_rdy",  {31'd0, instr_rdy}, 32'd1);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_wb",   {16'd0, wb_data}, 32'd0);
      check("mid_rst_a",    {16'd0, a}, 32'd0);
      check_reg("mid_rst_r1", 3'd1, 16'd0);
      check_reg("mid_rst_r3", 3'd3, 16'd0);
      step();
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_rdy",  {31'd0, instr_rdy}, 32'd1);

      // Normal operation resumes after the abort
      run_instr("post_add", 16'h040D, 3'd0, 16'd0, 16'd5, 16'd5, 1'b0);
      check_reg("post_add_r1", 3'd1, 16'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
